// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Purpose  : Multi-channel switch/button debouncer. Each channel runs
//            independently:
//              - a two-flop synchroniser brings raw[i] into clk;
//              - a stability counter accepts a new synchronised level only
//                after it has persisted for DB_CYCLES consecutive cycles;
//              - registered one-cycle pulses are produced on each accepted
//                edge.
// Ports    : clk    - sole clock, rising edge
//            reset  - asynchronous, active-high; clears all state
//            raw    - [N_CH] asynchronous switch/button levels
//            level  - [N_CH] debounced level
//            rise   - [N_CH] one-cycle pulse, level 0->1
//            fall   - [N_CH] one-cycle pulse, level 1->0
//            press  - [N_CH] rise, OR'd with auto-repeat pulses if enabled
// Options  : DEBOUNCE_AUTOREPEAT_EN - when defined, a held button re-issues
//            press pulses RPT_DELAY cycles after its rise pulse, then every
//            RPT_PERIOD cycles while level stays 1. When undefined, press is
//            identical to rise and RPT_DELAY/RPT_PERIOD are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bank #(
  parameter int N_CH       = 5,
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic             rise_q;
    logic             fall_q;
    logic             press_q;
    logic             accept;
    logic             press_set;

    // The synchronised level has differed from the accepted level for
    // DB_CYCLES sampled cycles: this edge commits s2 as the new level.
    assign accept = (s2 != lvl) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        lvl    <= 1'b0;
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1     <= raw[i];
        s2     <= s1;
        rise_q <= accept & s2;
        fall_q <= accept & ~s2;
        // Any return to the accepted level discards the partial count, so
        // glitches shorter than DB_CYCLES leave no trace.
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic [RPT_W-1:0] rcnt;
    logic             in_period;
    logic             rpt_due;

    // rcnt counts edges since the rise pulse (or since the last repeat).
    // A repeat is suppressed on the edge where the level drops, so a
    // coincident fall wins.
    assign rpt_due = lvl && !accept &&
                     (rcnt == (in_period ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt      <= '0;
        in_period <= 1'b0;
      end else if (!lvl || accept) begin
        // Idle while released; cleared on both the rise and fall edges.
        rcnt      <= '0;
        in_period <= 1'b0;
      end else if (rpt_due) begin
        rcnt      <= '0;
        in_period <= 1'b1;
      end else begin
        rcnt      <= rcnt + 1'b1;
      end
    end

    assign press_set = (accept & s2) | rpt_due;
`else
    assign press_set = accept & s2;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        press_q <= 1'b0;
      end else begin
        press_q <= press_set;
      end
    end

    assign level[i] = lvl;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_bank
// Purpose  : Self-checking bench for debounce_bank (N_CH=5, DB_CYCLES=4,
//            RPT_DELAY=10, RPT_PERIOD=3). Expected output bits are queued
//            against absolute edge numbers when stimulus is applied, and are
//            popped and compared 1 time unit after the matching clock edge.
//            Auto-repeat expectations follow DEBOUNCE_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int SEL_LEVEL = 0;
  localparam int SEL_RISE  = 1;
  localparam int SEL_FALL  = 2;
  localparam int SEL_PRESS = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] raw;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH       (N),
    .DB_CYCLES  (DB),
    .RPT_DELAY  (RD),
    .RPT_PERIOD (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .press (press)
  );

  typedef struct {
    int           at;
    int           sel;
    logic [N-1:0] mask;
    logic [N-1:0] val;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [N-1:0] pick(int sel);
    case (sel)
      SEL_LEVEL: return level;
      SEL_RISE:  return rise;
      SEL_FALL:  return fall;
      default:   return press;
    endcase
  endfunction

  task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(int at, int sel, logic [N-1:0] mask,
                           logic [N-1:0] val, string tag);
    exp_t e;
    e.at   = at;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val & mask;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // One clock edge; outputs sampled 1 unit later, then due entries popped.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, pick(sb[i].sel) & sb[i].mask, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int b;
    int e;
    raw = '0;
    #1 reset = 1'b1;
    #1;
    check("rst0_level", level, '0);
    check("rst0_rise",  rise,  '0);
    check("rst0_fall",  fall,  '0);
    check("rst0_press", press, '0);
    repeat (3) tick();
    reset = 1'b0;

    // All channels up, to give level a nonzero prior value.
    b = cyc;
    raw = '1;
    expect_at(b + 5, SEL_LEVEL, '1, '0, "pre_lvl_early");
    expect_at(b + 6, SEL_LEVEL, '1, '1, "pre_lvl_up");
    repeat (10) tick();

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("arst_level", level, '0);
    check("arst_rise",  rise,  '0);
    check("arst_fall",  fall,  '0);
    check("arst_press", press, '0);
    tick();
    reset = 1'b0;
    b = cyc;
    expect_at(b + 5, SEL_LEVEL, '1, '0, "rel_lvl_early");
    expect_at(b + 6, SEL_LEVEL, '1, '1, "rel_lvl_up");
    expect_at(b + 6, SEL_RISE,  '1, '1, "rel_rise");
    expect_at(b + 6, SEL_PRESS, '1, '1, "rel_press");
    expect_at(b + 7, SEL_RISE,  '1, '0, "rel_rise_off");
    wait_until(b + 12);

    // Release everything.
    raw = '0;
    b = cyc;
    expect_at(b + 5, SEL_LEVEL, '1, '1, "rel_all_hold");
    expect_at(b + 6, SEL_LEVEL, '1, '0, "rel_all_down");
    expect_at(b + 6, SEL_FALL,  '1, '1, "rel_all_fall");
    expect_at(b + 7, SEL_FALL,  '1, '0, "rel_all_fall_off");
    wait_until(b + 10);

    // Main window: ch0 clean press + hold (auto-repeat), ch3/ch4 up then
    // down together, ch2 glitch, ch1 bounce.
    b = cyc;
    e = b + 6;
    raw = 5'b11001;
    expect_at(e - 1, SEL_LEVEL, 5'b00001, 5'b00000, "ch0_lvl_early");
    for (int j = 0; j <= 45; j++) begin
      bit rep;
      rep = AR && (j >= RD) && (j < 37) && (((j - RD) % RP) == 0);
      expect_at(e + j, SEL_PRESS, 5'b00001, (j == 0 || rep) ? 5'b00001 : 5'b0,
                "ch0_press");
      expect_at(e + j, SEL_LEVEL, 5'b00001, (j < 37) ? 5'b00001 : 5'b0,
                "ch0_level");
      expect_at(e + j, SEL_RISE,  5'b00001, (j == 0) ? 5'b00001 : 5'b0,
                "ch0_rise");
      expect_at(e + j, SEL_FALL,  5'b00001, (j == 37) ? 5'b00001 : 5'b0,
                "ch0_fall");
    end
    expect_at(e, SEL_RISE, 5'b11000, 5'b11000, "ch34_rise");
    for (int t = b + 11; t <= b + 24; t++) begin
      expect_at(t, SEL_LEVEL, 5'b00100, 5'b0, "ch2_glitch_level");
      expect_at(t, SEL_RISE,  5'b00100, 5'b0, "ch2_glitch_rise");
      expect_at(t, SEL_FALL,  5'b00100, 5'b0, "ch2_glitch_fall");
    end
    for (int t = b + 11; t <= b + 27; t++) begin
      expect_at(t, SEL_RISE,  5'b00010, (t == b + 20) ? 5'b00010 : 5'b0,
                "ch1_bounce_rise");
      expect_at(t, SEL_LEVEL, 5'b00010, (t >= b + 20) ? 5'b00010 : 5'b0,
                "ch1_bounce_level");
    end
    expect_at(b + 25, SEL_LEVEL, 5'b11000, 5'b11000, "ch34_lvl_hold");
    expect_at(b + 26, SEL_LEVEL, 5'b11000, 5'b00000, "ch34_lvl_down");
    for (int t = b + 21; t <= b + 30; t++) begin
      expect_at(t, SEL_FALL, 5'b11000, (t == b + 26) ? 5'b11000 : 5'b0,
                "ch34_fall");
    end

    wait_until(b + 10);
    raw[1] = 1'b1;
    raw[2] = 1'b1;
    tick();
    raw[1] = 1'b0;
    tick();
    raw[1] = 1'b1;
    tick();
    raw[1] = 1'b0;
    raw[2] = 1'b0;
    tick();
    raw[1] = 1'b1;
    wait_until(b + 20);
    raw[4] = 1'b0;
    raw[3] = 1'b0;
    // Release ch0 so its fall lands on an edge where a repeat is also due.
    wait_until(e + 31);
    raw[0] = 1'b0;
    wait_until(e + 50);

    check("sb_drain", N'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
